byte_unstriping: RTL

BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

---
 rtl/byte_unstriping.sv | 121 ++++++++++++
 1 files changed

// File: rtl/byte_unstriping.sv
// rtl/byte_unstriping.sv - reassembles 4-lane striped words into a serial byte stream
// Two-entry word buffer feeds a byte counter; rx_Overrun latches any dropped word.
module byte_unstriping #(
   parameter logic [7:0] INACTIVE = 8'h00,
   parameter int         DEPTH    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic [7:0] rx_lane0,
   input  logic [7:0] rx_lane1,
   input  logic [7:0] rx_lane2,
   input  logic [7:0] rx_lane3,
   input  logic       rx_ValidL,
   output logic [7:0] rx_DataS,
   output logic       rx_ValidS,
   output logic       rx_Overrun
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [1:0] FULL = 2'(DEPTH);

   state_t      state, state_n;
   logic [1:0]  cnt, cnt_n;
   logic [1:0]  count, count_n;
   logic        rd_ptr, rd_ptr_n;
   logic        wr_ptr, wr_ptr_n;
   logic [7:0]  data_n;
   logic        valid_n;
   logic        overrun_n;
   logic        pop, accept, drop, full_after_pop;
   logic [31:0] head_word;
   logic [7:0]  head_byte;
   logic [31:0] mem [DEPTH];

   assign head_word = mem[rd_ptr];

   always_comb begin
      head_byte = head_word[7:0];
      case (cnt)
         2'd0:    head_byte = head_word[7:0];
         2'd1:    head_byte = head_word[15:8];
         2'd2:    head_byte = head_word[23:16];
         default: head_byte = head_word[31:24];
      endcase
   end

   // A pop on the same edge frees a slot, so a full buffer can still accept.
   assign pop            = enb && (state == SEND) && (cnt == 2'd3);
   assign full_after_pop = (count == FULL) && !pop;
   assign accept         = enb && rx_ValidL && !full_after_pop;
   assign drop           = enb && rx_ValidL && full_after_pop;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      count_n   = count;
      rd_ptr_n  = rd_ptr ^ pop;
      wr_ptr_n  = wr_ptr ^ accept;
      data_n    = rx_DataS;
      valid_n   = rx_ValidS;
      overrun_n = rx_Overrun | drop;

      case ({accept, pop})
         2'b10:   count_n = count + 2'd1;
         2'b01:   count_n = count - 2'd1;
         default: count_n = count;
      endcase

      if (enb) begin
         case (state)
            IDLE: begin
               data_n  = INACTIVE;
               valid_n = 1'b0;
               if (accept) begin
                  state_n = SEND;
                  cnt_n   = 2'd0;
               end
            end
            SEND: begin
               data_n  = head_byte;
               valid_n = 1'b1;
               cnt_n   = cnt + 2'd1;
               if (pop && count_n == 2'd0)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         count      <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         rx_DataS   <= INACTIVE;
         rx_ValidS  <= 1'b0;
         rx_Overrun <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         count      <= count_n;
         rd_ptr     <= rd_ptr_n;
         wr_ptr     <= wr_ptr_n;
         rx_DataS   <= data_n;
         rx_ValidS  <= valid_n;
         rx_Overrun <= overrun_n;
      end
   end

   // Word storage carries no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (!rst && accept)
         mem[wr_ptr] <= {rx_lane3, rx_lane2, rx_lane1, rx_lane0};
   end

endmodule
